alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 167 ++++++++++++++++
 tb/tb_alu_issue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Single-issue sequencer: decodes an instruction, reads two operands from a
// 32-entry register file, hands them to an external ALU and writes the result back.
module alu_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [XLEN-1:0] alu_op_a,
    output logic [XLEN-1:0] alu_op_b,
    output logic [6:0]      alu_op_code,
    output logic [5:0]      alu_ar_code,
    input  logic [XLEN-1:0] alu_out,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            err,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int unsigned NREGS = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      op_code_q, op_code_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [5:0]      ar_code_q, ar_code_d;
    logic            instr_ready_q, instr_ready_d;
    logic [XLEN-1:0] alu_op_a_q, alu_op_a_d;
    logic [XLEN-1:0] alu_op_b_q, alu_op_b_d;
    logic [6:0]      alu_op_code_q, alu_op_code_d;
    logic [5:0]      alu_ar_code_q, alu_ar_code_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    // Low nibble of the instruction word carries no information.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[3:0];

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        op_code_d     = op_code_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        ar_code_d     = ar_code_q;
        alu_op_a_d    = alu_op_a_q;
        alu_op_b_d    = alu_op_b_q;
        alu_op_code_d = alu_op_code_q;
        alu_ar_code_d = alu_ar_code_q;
        wb_valid_d    = 1'b0;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        err_d         = 1'b0;
        rf_d          = rf_q;

        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    op_code_d = instr[31:25];
                    rd_d      = instr[24:20];
                    rs1_d     = instr[19:15];
                    rs2_d     = instr[14:10];
                    ar_code_d = instr[9:4];
                    state_d   = READ;
                end
            end
            READ: begin
                // Operand registers double as the ALU-facing outputs.
                alu_op_a_d    = rf_q[rs1_q];
                alu_op_b_d    = rf_q[rs2_q];
                alu_op_code_d = op_code_q;
                alu_ar_code_d = ar_code_q;
                state_d       = EXEC;
            end
            EXEC: begin
                if (op_code_q != 7'd0) begin
                    err_d = 1'b1;
                end else if ((ar_code_q != 6'd0) && (rd_q != 5'd0)) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = rd_q;
                    wb_data_d  = alu_out;
                end
                state_d = WB;
            end
            WB: begin
                if (wb_valid_q) begin
                    rf_d[wb_addr_q] = wb_data_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        instr_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_code_q     <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            ar_code_q     <= '0;
            instr_ready_q <= 1'b1;
            alu_op_a_q    <= '0;
            alu_op_b_q    <= '0;
            alu_op_code_q <= '0;
            alu_ar_code_q <= '0;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            op_code_q     <= op_code_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            ar_code_q     <= ar_code_d;
            instr_ready_q <= instr_ready_d;
            alu_op_a_q    <= alu_op_a_d;
            alu_op_b_q    <= alu_op_b_d;
            alu_op_code_q <= alu_op_code_d;
            alu_ar_code_q <= alu_ar_code_d;
            wb_valid_q    <= wb_valid_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            err_q         <= err_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_op_a    = alu_op_a_q;
    assign alu_op_b    = alu_op_b_q;
    assign alu_op_code = alu_op_code_q;
    assign alu_ar_code = alu_ar_code_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign err         = err_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU attached.
module tb_alu_issue;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] alu_op_a;
    logic [XLEN-1:0] alu_op_b;
    logic [6:0]      alu_op_code;
    logic [5:0]      alu_ar_code;
    logic [XLEN-1:0] alu_out;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            err;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_op_code (alu_op_code),
        .alu_ar_code (alu_ar_code),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ALU: ar[5] set -> immediate ar[4:0]; ar==2 -> subtract; otherwise add.
    assign alu_out = alu_ar_code[5] ? XLEN'(alu_ar_code[4:0]) :
                     (alu_ar_code == 6'd2) ? (alu_op_a - alu_op_b) : (alu_op_a + alu_op_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [5:0] ar);
        return {op, rd, rs1, rs2, ar, 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_dbg(input logic [4:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Issue one instruction and check every cycle until the block is ready again.
    task automatic do_instr(input logic [31:0] iw, input logic [31:0] ea, input logic [31:0] eb,
                            input logic ewb, input logic [4:0] eaddr, input logic [31:0] edata,
                            input logic eerr, input bit hold, input string tag);
        logic [6:0] op;
        logic [5:0] ar;
        op = iw[31:25];
        ar = iw[9:4];
        chk({tag, "_ready_pre"}, 32'(instr_ready), 32'd1);
        instr = iw;
        instr_valid = 1'b1;
        tick();
        if (hold) instr = mk(7'd0, 5'd9, 5'd1, 5'd1, 6'h3F);
        else instr_valid = 1'b0;
        chk({tag, "_ready_c1"}, 32'(instr_ready), 32'd0);
        tick();
        if (hold) instr = mk(7'd3, 5'd10, 5'd2, 5'd2, 6'h21);
        chk({tag, "_ready_c2"}, 32'(instr_ready), 32'd0);
        chk({tag, "_exec_a"}, alu_op_a, ea);
        chk({tag, "_exec_b"}, alu_op_b, eb);
        chk({tag, "_exec_op"}, 32'(alu_op_code), 32'(op));
        chk({tag, "_exec_ar"}, 32'(alu_ar_code), 32'(ar));
        chk({tag, "_exec_wbv"}, 32'(wb_valid), 32'd0);
        tick();
        if (hold) instr = mk(7'd0, 5'd11, 5'd1, 5'd1, 6'h22);
        chk({tag, "_ready_c3"}, 32'(instr_ready), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(ewb));
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        if (ewb) begin
            chk({tag, "_wb_addr"}, 32'(wb_addr), 32'(eaddr));
            chk({tag, "_wb_data"}, wb_data, edata);
        end
        tick();
        instr_valid = 1'b0;
        chk({tag, "_ready_post"}, 32'(instr_ready), 32'd1);
        chk({tag, "_wbv_post"}, 32'(wb_valid), 32'd0);
        chk({tag, "_err_post"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        dbg_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wbaddr", 32'(wb_addr), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_opa", alu_op_a, 32'd0);
        chk("rst_opcode", 32'(alu_op_code), 32'd0);
        chk("rst_arcode", 32'(alu_ar_code), 32'd0);
        rd_dbg(5'd0, 32'd0, "rst_dbg0");

        // Preload r1=5, r2=7 via immediates.
        do_instr(mk(7'd0, 5'd1, 5'd0, 5'd0, 6'h25), 0, 0, 1'b1, 5'd1, 32'd5, 1'b0, 0, "ld1");
        do_instr(mk(7'd0, 5'd2, 5'd0, 5'd0, 6'h27), 0, 0, 1'b1, 5'd2, 32'd7, 1'b0, 0, "ld2");
        rd_dbg(5'd1, 32'd5, "dbg_r1");
        rd_dbg(5'd2, 32'd7, "dbg_r2");

        // r3 = r1 + r2, then dependent r4 = r3 + r3.
        do_instr(mk(7'd0, 5'd3, 5'd1, 5'd2, 6'h01), 32'd5, 32'd7, 1'b1, 5'd3, 32'd12, 1'b0, 0, "add3");
        rd_dbg(5'd3, 32'd12, "dbg_r3");
        do_instr(mk(7'd0, 5'd4, 5'd3, 5'd3, 6'h01), 32'd12, 32'd12, 1'b1, 5'd4, 32'd24, 1'b0, 0, "add4");
        rd_dbg(5'd4, 32'd24, "dbg_r4");

        // Subtract path: r5 = r2 - r1.
        do_instr(mk(7'd0, 5'd5, 5'd2, 5'd1, 6'h02), 32'd7, 32'd5, 1'b1, 5'd5, 32'd2, 1'b0, 0, "sub5");

        // Illegal opcode targeting r6.
        do_instr(mk(7'h05, 5'd6, 5'd1, 5'd2, 6'h01), 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b1, 0, "illegal");
        rd_dbg(5'd1, 32'd5, "ill_r1");
        rd_dbg(5'd3, 32'd12, "ill_r3");
        rd_dbg(5'd4, 32'd24, "ill_r4");
        rd_dbg(5'd6, 32'd0, "ill_r6");

        // rd=0 and NOP produce no writeback.
        do_instr(mk(7'd0, 5'd0, 5'd1, 5'd2, 6'h01), 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 0, "rd0");
        rd_dbg(5'd0, 32'd0, "rd0_dbg0");
        do_instr(mk(7'd0, 5'd7, 5'd1, 5'd2, 6'h00), 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 0, "nop");
        rd_dbg(5'd7, 32'd0, "nop_r7");

        // instr_valid held with changing instr during READ/EXEC/WB.
        do_instr(mk(7'd0, 5'd8, 5'd1, 5'd2, 6'h01), 32'd5, 32'd7, 1'b1, 5'd8, 32'd12, 1'b0, 1, "hold");
        rd_dbg(5'd8, 32'd12, "hold_r8");
        rd_dbg(5'd9, 32'd0, "hold_r9");
        rd_dbg(5'd10, 32'd0, "hold_r10");
        rd_dbg(5'd11, 32'd0, "hold_r11");
        tick();
        chk("hold_idle_wbv", 32'(wb_valid), 32'd0);
        chk("hold_idle_ready", 32'(instr_ready), 32'd1);

        // Reset asserted during EXEC of r12 = r1 + r2.
        instr = mk(7'd0, 5'd12, 5'd1, 5'd2, 6'h01);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("rx_exec_a", alu_op_a, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rx_ready", 32'(instr_ready), 32'd1);
        chk("rx_opa", alu_op_a, 32'd0);
        chk("rx_opb", alu_op_b, 32'd0);
        chk("rx_arcode", 32'(alu_ar_code), 32'd0);
        chk("rx_wbv", 32'(wb_valid), 32'd0);
        chk("rx_wbdata", wb_data, 32'd0);
        rd_dbg(5'd1, 32'd0, "rx_r1");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rx_ready_rel", 32'(instr_ready), 32'd1);
        chk("rx_wbv_rel", 32'(wb_valid), 32'd0);
        rd_dbg(5'd12, 32'd0, "rx_r12");

        // Block works again after reset.
        do_instr(mk(7'd0, 5'd1, 5'd0, 5'd0, 6'h2A), 0, 0, 1'b1, 5'd1, 32'd10, 1'b0, 0, "post_rst");
        rd_dbg(5'd1, 32'd10, "post_r1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
